// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// mem_bus_arbiter : serialises fetch and MEM data accesses onto one SRAM-like bus
// Revision 1.0
// ============================================================================
module mem_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              flush_i,
  input  logic              inst_req_i,
  input  logic [ADDR_W-1:0] inst_addr_i,
  output logic [DATA_W-1:0] inst_rdata_o,
  output logic              inst_stall_o,
  input  logic              data_rd_en_i,
  input  logic              data_wr_en_i,
  input  logic [ADDR_W-1:0] data_addr_i,
  input  logic [3:0]        data_wsel_i,
  input  logic [DATA_W-1:0] data_wdata_i,
  output logic [DATA_W-1:0] data_rdata_o,
  output logic              data_stall_o,
  output logic              bus_req_o,
  output logic              bus_wr_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [3:0]        bus_wstrb_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic              bus_addr_ok_i,
  input  logic              bus_data_ok_i,
  input  logic [DATA_W-1:0] bus_rdata_i
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_D_ADDR = 3'd1,
    S_D_DATA = 3'd2,
    S_I_ADDR = 3'd3,
    S_I_DATA = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic              inst_done_q, inst_done_d;
  logic              data_done_q, data_done_d;
  logic              discard_q, discard_d;
  logic [DATA_W-1:0] inst_rdata_q, inst_rdata_d;
  logic [DATA_W-1:0] data_rdata_q, data_rdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_q, wr_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic data_pend;
  logic inst_pend;
  logic advance;
  logic is_data;
  logic complete;
  logic kill;

  assign data_pend    = (data_rd_en_i | data_wr_en_i) & ~data_done_q;
  assign inst_pend    = inst_req_i & ~inst_done_q;
  assign data_stall_o = data_pend;
  assign inst_stall_o = inst_pend;
  assign advance      = ~data_pend & ~inst_pend;

  assign bus_req_o    = (state_q == S_D_ADDR) || (state_q == S_I_ADDR);
  assign bus_wr_o     = wr_q;
  assign bus_addr_o   = addr_q;
  assign bus_wstrb_o  = wstrb_q;
  assign bus_wdata_o  = wdata_q;
  assign inst_rdata_o = inst_rdata_q;
  assign data_rdata_o = data_rdata_q;

  always_comb begin
    state_d      = state_q;
    inst_done_d  = inst_done_q;
    data_done_d  = data_done_q;
    discard_d    = discard_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    addr_d       = addr_q;
    wr_d         = wr_q;
    wstrb_d      = wstrb_q;
    wdata_d      = wdata_q;
    complete     = 1'b0;
    is_data      = (state_q == S_D_ADDR) || (state_q == S_D_DATA);
    kill         = flush_i | discard_q;

    case (state_q)
      S_IDLE: begin
        // Done flags are stale during a flush, so nothing is launched that cycle.
        if (!flush_i) begin
          if (data_pend) begin
            state_d = S_D_ADDR;
            addr_d  = data_addr_i;
            wr_d    = data_wr_en_i;
            wstrb_d = data_wr_en_i ? data_wsel_i : 4'b0000;
            wdata_d = data_wr_en_i ? data_wdata_i : '0;
          end else if (inst_pend) begin
            state_d = S_I_ADDR;
            addr_d  = inst_addr_i;
            wr_d    = 1'b0;
            wstrb_d = 4'b0000;
            wdata_d = '0;
          end
        end
      end
      S_D_ADDR, S_I_ADDR: begin
        if (bus_addr_ok_i) begin
          if (bus_data_ok_i) begin
            state_d  = S_IDLE;
            complete = 1'b1;
          end else begin
            state_d   = (state_q == S_D_ADDR) ? S_D_DATA : S_I_DATA;
            discard_d = flush_i;
          end
        end else if (flush_i) begin
          state_d = S_IDLE;
        end
      end
      S_D_DATA, S_I_DATA: begin
        if (flush_i) begin
          discard_d = 1'b1;
        end
        if (bus_data_ok_i) begin
          state_d   = S_IDLE;
          complete  = 1'b1;
          discard_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (advance || flush_i) begin
      inst_done_d = 1'b0;
      data_done_d = 1'b0;
    end

    // A response belonging to a flushed access is consumed but leaves no trace.
    if (complete && !kill) begin
      if (is_data) begin
        data_done_d = 1'b1;
        if (!wr_q) begin
          data_rdata_d = bus_rdata_i;
        end
      end else begin
        inst_done_d  = 1'b1;
        inst_rdata_d = bus_rdata_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      inst_done_q  <= 1'b0;
      data_done_q  <= 1'b0;
      discard_q    <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
      addr_q       <= '0;
      wr_q         <= 1'b0;
      wstrb_q      <= 4'b0000;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      inst_done_q  <= inst_done_d;
      data_done_q  <= data_done_d;
      discard_q    <= discard_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
      addr_q       <= addr_d;
      wr_q         <= wr_d;
      wstrb_q      <= wstrb_d;
      wdata_q      <= wdata_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_bus_arbiter : randomized bus-slave bench for mem_bus_arbiter
// Revision 1.0
// ============================================================================
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset_i, flush_i;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata_o;
  logic        inst_stall_o;
  logic        data_rd_en, data_wr_en;
  logic [31:0] data_addr;
  logic [3:0]  data_wsel;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata_o;
  logic        data_stall_o;
  logic        bus_req_o, bus_wr_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_wstrb_o;
  logic [31:0] bus_wdata_o;
  logic        bus_addr_ok, bus_data_ok;
  logic [31:0] bus_rdata;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i(clk), .reset_i(reset_i), .flush_i(flush_i),
    .inst_req_i(inst_req), .inst_addr_i(inst_addr),
    .inst_rdata_o(inst_rdata_o), .inst_stall_o(inst_stall_o),
    .data_rd_en_i(data_rd_en), .data_wr_en_i(data_wr_en),
    .data_addr_i(data_addr), .data_wsel_i(data_wsel), .data_wdata_i(data_wdata),
    .data_rdata_o(data_rdata_o), .data_stall_o(data_stall_o),
    .bus_req_o(bus_req_o), .bus_wr_o(bus_wr_o), .bus_addr_o(bus_addr_o),
    .bus_wstrb_o(bus_wstrb_o), .bus_wdata_o(bus_wdata_o),
    .bus_addr_ok_i(bus_addr_ok), .bus_data_ok_i(bus_data_ok), .bus_rdata_i(bus_rdata)
  );

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } txn_t;

  txn_t        log_q[$];
  int          amin = 0, amax = 0, dmin = 1, dmax = 1;
  bit          hold_data = 0;
  bit          ovr_en = 0;
  logic [31:0] ovr_val = 32'h0;
  int          proto_viol = 0;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_inst_rdata = 32'h0;
  logic [31:0] exp_data_rdata = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  // Bus slave: random accept/response delays, logs every accepted request.
  initial begin : slave
    int          addr_wait;
    int          data_wait;
    bit          busy;
    bit          ok_last;
    logic [31:0] cur_addr;
    txn_t        t;
    addr_wait = -1; data_wait = 0; busy = 0; ok_last = 0; cur_addr = 32'h0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'h0;
    forever begin
      @(posedge clk); #2;
      bus_addr_ok = 1'b0;
      bus_data_ok = 1'b0;
      if (reset_i) begin
        busy = 0; addr_wait = -1; ok_last = 0;
      end else begin
        if (bus_req_o && (busy || ok_last)) proto_viol++;
        ok_last = 0;
        if (busy) begin
          if (!hold_data) begin
            if (data_wait == 0) begin
              bus_data_ok = 1'b1;
              bus_rdata   = ovr_en ? ovr_val : mem_word(cur_addr);
              ovr_en      = 0;
              busy        = 0;
              ok_last     = 1;
            end else begin
              data_wait--;
            end
          end
        end else if (bus_req_o) begin
          if (addr_wait < 0) addr_wait = int'($urandom_range(amax, amin));
          if (addr_wait == 0) begin
            addr_wait   = -1;
            bus_addr_ok = 1'b1;
            t.addr = bus_addr_o; t.wr = bus_wr_o; t.wstrb = bus_wstrb_o; t.wdata = bus_wdata_o;
            log_q.push_back(t);
            cur_addr  = bus_addr_o;
            data_wait = int'($urandom_range(dmax, dmin));
            if (data_wait == 0 && !hold_data) begin
              bus_data_ok = 1'b1;
              bus_rdata   = ovr_en ? ovr_val : mem_word(cur_addr);
              ovr_en      = 0;
              ok_last     = 1;
            end else begin
              busy = 1;
              if (data_wait > 0) data_wait--;
            end
          end else begin
            addr_wait--;
          end
        end else begin
          addr_wait = -1;
        end
      end
    end
  end

  task automatic clear_inputs;
    flush_i = 0; inst_req = 0; inst_addr = 32'h0;
    data_rd_en = 0; data_wr_en = 0; data_addr = 32'h0;
    data_wsel = 4'h0; data_wdata = 32'h0;
  endtask

  task automatic test_reset;
    reset_i = 1; clear_inputs(); inst_req = 1;
    repeat (3) @(negedge clk);
    checks++; if (bus_req_o !== 1'b0) begin errors++; $display("FAIL rst_bus_req: got %b want 0", bus_req_o); end
    checks++; if (bus_wr_o !== 1'b0) begin errors++; $display("FAIL rst_bus_wr: got %b want 0", bus_wr_o); end
    checks++; if (bus_addr_o !== 32'h0) begin errors++; $display("FAIL rst_bus_addr: got %h want 0", bus_addr_o); end
    checks++; if (bus_wstrb_o !== 4'h0) begin errors++; $display("FAIL rst_bus_wstrb: got %h want 0", bus_wstrb_o); end
    checks++; if (bus_wdata_o !== 32'h0) begin errors++; $display("FAIL rst_bus_wdata: got %h want 0", bus_wdata_o); end
    checks++; if (inst_rdata_o !== 32'h0) begin errors++; $display("FAIL rst_inst_rdata: got %h want 0", inst_rdata_o); end
    checks++; if (data_rdata_o !== 32'h0) begin errors++; $display("FAIL rst_data_rdata: got %h want 0", data_rdata_o); end
    checks++; if (inst_stall_o !== 1'b1) begin errors++; $display("FAIL rst_inst_stall: got %b want 1", inst_stall_o); end
    checks++; if (data_stall_o !== 1'b0) begin errors++; $display("FAIL rst_data_stall: got %b want 0", data_stall_o); end
    inst_req = 0; reset_i = 0;
    @(negedge clk);
  endtask

  task automatic test_load;
    int n; logic req1;
    amin = 0; amax = 0; dmin = 1; dmax = 1; ovr_en = 1; ovr_val = 32'hDEADBEEF;
    @(negedge clk); clear_inputs();
    @(negedge clk); log_q.delete();
    data_rd_en = 1; data_addr = 32'h1000;
    n = 0; req1 = 0;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (k == 1) req1 = bus_req_o;
      if (!data_stall_o) begin n = k; break; end
    end
    checks++; if (req1 !== 1'b1) begin errors++; $display("FAIL load_req_cycle1: got %b want 1", req1); end
    checks++; if (n != 3) begin errors++; $display("FAIL load_latency: got %0d want 3", n); end
    checks++; if (log_q.size() != 1) begin errors++; $display("FAIL load_txn_count: got %0d want 1", log_q.size()); end
    if (log_q.size() > 0) begin
      checks++;
      if (log_q[0].addr !== 32'h1000 || log_q[0].wr !== 1'b0 || log_q[0].wstrb !== 4'h0) begin
        errors++; $display("FAIL load_txn: got addr=%h wr=%b strb=%h want 1000/0/0",
                           log_q[0].addr, log_q[0].wr, log_q[0].wstrb);
      end
    end
    exp_data_rdata = 32'hDEADBEEF;
    checks++; if (data_rdata_o !== exp_data_rdata) begin errors++; $display("FAIL load_rdata: got %h want %h", data_rdata_o, exp_data_rdata); end
    // zero-wait bus: stall drops two cycles after the request
    dmin = 0; dmax = 0;
    @(negedge clk); data_addr = 32'h1004;
    n = 0;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (!data_stall_o) begin n = k; break; end
    end
    exp_data_rdata = mem_word(32'h1004);
    checks++; if (n != 2) begin errors++; $display("FAIL load_min_latency: got %0d want 2", n); end
    checks++; if (data_rdata_o !== exp_data_rdata) begin errors++; $display("FAIL load2_rdata: got %h want %h", data_rdata_o, exp_data_rdata); end
    checks++; if (log_q.size() != 2) begin errors++; $display("FAIL load2_txn_count: got %0d want 2", log_q.size()); end
  endtask

  task automatic test_store;
    int n;
    amin = 0; amax = 0; dmin = 1; dmax = 1;
    @(negedge clk); clear_inputs();
    @(negedge clk); log_q.delete();
    data_wr_en = 1; data_addr = 32'h2000; data_wsel = 4'b1000; data_wdata = 32'hABABABAB;
    @(negedge clk);
    checks++; if (bus_req_o !== 1'b1 || bus_wr_o !== 1'b1) begin errors++; $display("FAIL sb_req_wr: got %b%b want 11", bus_req_o, bus_wr_o); end
    checks++; if (bus_addr_o !== 32'h2000) begin errors++; $display("FAIL sb_addr: got %h want 00002000", bus_addr_o); end
    checks++; if (bus_wstrb_o !== 4'b1000) begin errors++; $display("FAIL sb_wstrb: got %b want 1000", bus_wstrb_o); end
    checks++; if (bus_wdata_o !== 32'hABABABAB) begin errors++; $display("FAIL sb_wdata: got %h want abababab", bus_wdata_o); end
    n = 0;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (!data_stall_o) begin n = k; break; end
    end
    checks++; if (n == 0) begin errors++; $display("FAIL sb_timeout: got stall stuck want release"); end
    checks++; if (data_rdata_o !== exp_data_rdata) begin errors++; $display("FAIL sb_rdata_kept: got %h want %h", data_rdata_o, exp_data_rdata); end
    checks++; if (log_q.size() != 1) begin errors++; $display("FAIL sb_txn_count: got %0d want 1", log_q.size()); end
  endtask

  task automatic test_priority;
    int nd, ni, bad;
    amin = 0; amax = 1; dmin = 0; dmax = 1;
    @(negedge clk); clear_inputs();
    @(negedge clk); log_q.delete();
    inst_req = 1; inst_addr = 32'h3000; data_rd_en = 1; data_addr = 32'h4000;
    nd = 0; ni = 0; bad = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (nd == 0 && !data_stall_o) nd = k;
      if (nd != 0 && data_stall_o) bad++;
      if (!inst_stall_o) begin ni = k; break; end
    end
    exp_data_rdata = mem_word(32'h4000);
    exp_inst_rdata = mem_word(32'h3000);
    checks++; if (!(nd != 0 && nd < ni)) begin errors++; $display("FAIL prio_order: got data_done@%0d inst_done@%0d want data first", nd, ni); end
    checks++; if (bad != 0) begin errors++; $display("FAIL prio_dstall_reassert: got %0d want 0", bad); end
    checks++; if (data_stall_o !== 1'b0) begin errors++; $display("FAIL prio_dstall_end: got %b want 0", data_stall_o); end
    checks++; if (log_q.size() != 2) begin errors++; $display("FAIL prio_txn_count: got %0d want 2", log_q.size()); end
    if (log_q.size() == 2) begin
      checks++; if (log_q[0].addr !== 32'h4000) begin errors++; $display("FAIL prio_first: got %h want 00004000", log_q[0].addr); end
      checks++; if (log_q[1].addr !== 32'h3000) begin errors++; $display("FAIL prio_second: got %h want 00003000", log_q[1].addr); end
    end
    checks++; if (data_rdata_o !== exp_data_rdata) begin errors++; $display("FAIL prio_drdata: got %h want %h", data_rdata_o, exp_data_rdata); end
    checks++; if (inst_rdata_o !== exp_inst_rdata) begin errors++; $display("FAIL prio_irdata: got %h want %h", inst_rdata_o, exp_inst_rdata); end
    @(negedge clk); clear_inputs();
    repeat (4) @(negedge clk);
    checks++; if (log_q.size() != 2) begin errors++; $display("FAIL prio_reissue: got %0d txns want 2", log_q.size()); end
  endtask

  task automatic test_addr_hold;
    int reqc, n;
    amin = 5; amax = 5; dmin = 1; dmax = 1;
    @(negedge clk); clear_inputs();
    @(negedge clk); log_q.delete();
    data_wr_en = 1; data_addr = 32'h5550; data_wsel = 4'b0011; data_wdata = 32'h12345678;
    reqc = 0; n = 0;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (bus_req_o) begin
        reqc++;
        checks++;
        if (bus_addr_o !== 32'h5550 || bus_wdata_o !== 32'h12345678 || bus_wstrb_o !== 4'b0011 || bus_wr_o !== 1'b1) begin
          errors++; $display("FAIL hold_fields: got %h/%h/%b/%b want 00005550/12345678/0011/1",
                             bus_addr_o, bus_wdata_o, bus_wstrb_o, bus_wr_o);
        end
        checks++; if (data_stall_o !== 1'b1) begin errors++; $display("FAIL hold_stall: got %b want 1", data_stall_o); end
      end
      if (!data_stall_o) begin n = k; break; end
    end
    checks++; if (reqc != 6) begin errors++; $display("FAIL hold_req_cycles: got %0d want 6", reqc); end
    checks++; if (n == 0) begin errors++; $display("FAIL hold_timeout: got stall stuck want release"); end
    amin = 0; amax = 0;
  endtask

  task automatic test_flush;
    int n;
    amin = 0; amax = 0; dmin = 1; dmax = 1;
    @(negedge clk); clear_inputs();
    @(negedge clk); log_q.delete();
    hold_data = 1;
    inst_req = 1; inst_addr = 32'h6000;
    n = 0;
    while (log_q.size() == 0 && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    checks++; if (bus_req_o !== 1'b0 || log_q.size() != 1) begin errors++; $display("FAIL flush_setup: got req=%b txns=%0d want 0/1", bus_req_o, log_q.size()); end
    flush_i = 1; inst_addr = 32'h7000;
    @(negedge clk);
    flush_i = 0; ovr_en = 1; ovr_val = 32'h12345678; hold_data = 0;
    repeat (2) @(negedge clk);
    checks++; if (inst_stall_o !== 1'b1) begin errors++; $display("FAIL flush_no_done: got stall=%b want 1", inst_stall_o); end
    checks++; if (inst_rdata_o !== exp_inst_rdata) begin errors++; $display("FAIL flush_no_latch: got %h want %h", inst_rdata_o, exp_inst_rdata); end
    n = 0;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (!inst_stall_o) begin n = k; break; end
    end
    exp_inst_rdata = mem_word(32'h7000);
    checks++; if (n == 0) begin errors++; $display("FAIL flush_refetch_timeout: got stall stuck want release"); end
    checks++; if (log_q.size() != 2) begin errors++; $display("FAIL flush_txn_count: got %0d want 2", log_q.size()); end
    if (log_q.size() == 2) begin
      checks++; if (log_q[1].addr !== 32'h7000) begin errors++; $display("FAIL flush_refetch_addr: got %h want 00007000", log_q[1].addr); end
    end
    checks++; if (inst_rdata_o !== exp_inst_rdata) begin errors++; $display("FAIL flush_refetch_rdata: got %h want %h", inst_rdata_o, exp_inst_rdata); end
    // flush while the address phase is still waiting drops that request
    @(negedge clk); clear_inputs();
    @(negedge clk); log_q.delete();
    amin = 8; amax = 8;
    inst_req = 1; inst_addr = 32'h8000;
    repeat (2) @(negedge clk);
    checks++; if (bus_req_o !== 1'b1) begin errors++; $display("FAIL flush_addr_setup: got %b want 1", bus_req_o); end
    flush_i = 1; inst_addr = 32'h9000;
    @(negedge clk);
    flush_i = 0; amin = 0; amax = 0;
    checks++; if (bus_req_o !== 1'b0) begin errors++; $display("FAIL flush_addr_drop: got %b want 0", bus_req_o); end
    n = 0;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (!inst_stall_o) begin n = k; break; end
    end
    exp_inst_rdata = mem_word(32'h9000);
    checks++; if (log_q.size() != 1) begin errors++; $display("FAIL flush_addr_txns: got %0d want 1", log_q.size()); end
    if (log_q.size() == 1) begin
      checks++; if (log_q[0].addr !== 32'h9000) begin errors++; $display("FAIL flush_addr_new: got %h want 00009000", log_q[0].addr); end
    end
    checks++; if (inst_rdata_o !== exp_inst_rdata || n == 0) begin errors++; $display("FAIL flush_addr_rdata: got %h want %h", inst_rdata_o, exp_inst_rdata); end
  endtask

  task automatic test_random;
    txn_t exp_q[$];
    txn_t t;
    bit ireq; int dop, n;
    @(negedge clk); clear_inputs();
    @(negedge clk); log_q.delete();
    for (int s = 0; s < 40; s++) begin
      amin = 0; amax = int'($urandom_range(3, 0));
      dmin = 0; dmax = int'($urandom_range(3, 0));
      ireq = ($urandom_range(4, 0) != 0);
      dop  = int'($urandom_range(2, 0));
      exp_q.delete();
      log_q.delete();
      @(negedge clk);
      inst_req   = ireq;
      inst_addr  = $urandom & 32'h0000FFFC;
      data_rd_en = (dop == 1);
      data_wr_en = (dop == 2);
      data_addr  = $urandom & 32'h0000FFFC;
      data_wsel  = 4'($urandom_range(15, 1));
      data_wdata = $urandom;
      if (dop != 0) begin
        t.addr = data_addr; t.wr = (dop == 2);
        t.wstrb = (dop == 2) ? data_wsel : 4'h0; t.wdata = data_wdata;
        exp_q.push_back(t);
        if (dop == 1) exp_data_rdata = mem_word(data_addr);
      end
      if (ireq) begin
        t.addr = inst_addr; t.wr = 1'b0; t.wstrb = 4'h0; t.wdata = 32'h0;
        exp_q.push_back(t);
        exp_inst_rdata = mem_word(inst_addr);
      end
      n = 0;
      for (int k = 1; k <= 300; k++) begin
        @(negedge clk);
        if (!inst_stall_o && !data_stall_o) begin n = k; break; end
      end
      checks++; if (n == 0) begin errors++; $display("FAIL rnd_timeout step %0d: got stalls %b%b want 00", s, inst_stall_o, data_stall_o); end
      checks++; if (log_q.size() != exp_q.size()) begin errors++; $display("FAIL rnd_txn_count step %0d: got %0d want %0d", s, log_q.size(), exp_q.size()); end
      for (int j = 0; j < exp_q.size(); j++) begin
        if (j < log_q.size()) begin
          checks++;
          if (log_q[j].addr !== exp_q[j].addr || log_q[j].wr !== exp_q[j].wr || log_q[j].wstrb !== exp_q[j].wstrb ||
              (exp_q[j].wr && log_q[j].wdata !== exp_q[j].wdata)) begin
            errors++; $display("FAIL rnd_txn step %0d.%0d: got %h/%b/%h/%h want %h/%b/%h/%h", s, j,
                               log_q[j].addr, log_q[j].wr, log_q[j].wstrb, log_q[j].wdata,
                               exp_q[j].addr, exp_q[j].wr, exp_q[j].wstrb, exp_q[j].wdata);
          end
        end
      end
      checks++; if (inst_rdata_o !== exp_inst_rdata) begin errors++; $display("FAIL rnd_irdata step %0d: got %h want %h", s, inst_rdata_o, exp_inst_rdata); end
      checks++; if (data_rdata_o !== exp_data_rdata) begin errors++; $display("FAIL rnd_drdata step %0d: got %h want %h", s, data_rdata_o, exp_data_rdata); end
    end
    checks++; if (proto_viol != 0) begin errors++; $display("FAIL bus_protocol: got %0d violations want 0", proto_viol); end
  endtask

  task automatic test_reset_mid;
    int n;
    amin = 0; amax = 0; dmin = 1; dmax = 1;
    @(negedge clk); clear_inputs();
    @(negedge clk); log_q.delete();
    hold_data = 1;
    data_rd_en = 1; data_addr = 32'hA000;
    n = 0;
    while (log_q.size() == 0 && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    reset_i = 1;
    @(negedge clk);
    checks++; if (bus_req_o !== 1'b0) begin errors++; $display("FAIL rstmid_req: got %b want 0", bus_req_o); end
    checks++; if (data_rdata_o !== 32'h0 || inst_rdata_o !== 32'h0) begin errors++; $display("FAIL rstmid_rdata: got %h/%h want 0/0", data_rdata_o, inst_rdata_o); end
    checks++; if (data_stall_o !== 1'b1) begin errors++; $display("FAIL rstmid_done_flag: got stall %b want 1", data_stall_o); end
    checks++; if (bus_addr_o !== 32'h0) begin errors++; $display("FAIL rstmid_addr: got %h want 0", bus_addr_o); end
    reset_i = 0; hold_data = 0; data_rd_en = 0;
    @(negedge clk);
    checks++; if (bus_req_o !== 1'b0 || data_stall_o !== 1'b0) begin errors++; $display("FAIL rstmid_idle: got req=%b stall=%b want 0/0", bus_req_o, data_stall_o); end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    test_reset();
    test_load();
    test_store();
    test_priority();
    test_addr_hold();
    test_flush();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
